// File: rtl/cwb_pkg.sv
//------------------------------------------------------------------------------
// Module  : cwb_pkg
// Brief   : Shared types and geometry helpers for conv_window_buf.
//           Honours CWB_ZERO_PAD_EN (zero-padded "same" output geometry).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package cwb_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_FILT = 3'd1,
    S_LOAD_IMG  = 3'd2,
    S_CONV      = 3'd3,
    S_DONE      = 3'd4
  } cwb_state_t;

  function automatic int pad_of(input int k);
`ifdef CWB_ZERO_PAD_EN
    return (k - 1) / 2;
`else
    return 0;
`endif
  endfunction

  function automatic int out_w(input int img_w, input int k);
    return img_w - k + 1 + 2 * pad_of(k);
  endfunction

  function automatic int out_h(input int img_h, input int k);
    return img_h - k + 1 + 2 * pad_of(k);
  endfunction

  function automatic int filt_words(input int k, input int pix_w, input int in_w);
    return (k * k * pix_w + in_w - 1) / in_w;
  endfunction

  function automatic int img_words(input int img_w, input int img_h, input int pix_w,
                                   input int in_w);
    return (img_w * img_h * pix_w + in_w - 1) / in_w;
  endfunction

  // Pixel slot of kernel tap (r,c) inside a packed window, row-major.
  function automatic int win_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cwb_res_mem.sv
//------------------------------------------------------------------------------
// Module  : cwb_res_mem
// Brief   : Result storage, one write port and a registered read port that
//           returns 0 for addresses beyond DEPTH.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cwb_res_mem #(
  parameter int DEPTH = 784,
  parameter int RES_W = 20,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [RES_W-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [RES_W-1:0] rd_data
);

  logic [RES_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (32'(rd_addr) < 32'(DEPTH)) begin
      rd_data <= r_mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_window_buf.sv
//------------------------------------------------------------------------------
// Module  : conv_window_buf
// Brief   : Loads a filter and an image, streams KxK windows in raster order
//           and collects results. CWB_ZERO_PAD_EN enables zero padding.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module conv_window_buf
  import cwb_pkg::*;
#(
  parameter int IMG_W = 30,
  parameter int IMG_H = 30,
  parameter int K     = 3,
  parameter int PIX_W = 8,
  parameter int IN_W  = 32,
  parameter int RES_W = 20,
  localparam int OW    = out_w(IMG_W, K),
  localparam int OH    = out_h(IMG_H, K),
  localparam int N_WIN = OW * OH,
  localparam int RA_W  = (N_WIN > 1) ? $clog2(N_WIN) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 filt_valid,
  input  logic                 img_valid,
  input  logic [IN_W-1:0]      in_data,
  output logic                 in_ready,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [K*K*PIX_W-1:0] win_data,
  output logic [K*K*PIX_W-1:0] filt_data,
  input  logic                 res_valid,
  input  logic [RES_W-1:0]     res_data,
  input  logic [RA_W-1:0]      rd_addr,
  output logic [RES_W-1:0]     rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int PPW    = IN_W / PIX_W;
  localparam int FW     = filt_words(K, PIX_W, IN_W);
  localparam int IW     = img_words(IMG_W, IMG_H, PIX_W, IN_W);
  localparam int IMG_N  = IMG_W * IMG_H;
  localparam int PAD    = pad_of(K);
  localparam int WIN_W  = K * K * PIX_W;
  localparam int PIX_AW = (IMG_N > 1) ? $clog2(IMG_N) : 1;

  cwb_state_t r_state, w_next;

  logic [31:0]       r_word_cnt, r_pix_cnt, r_col, r_row, r_hs_cnt, r_wr_cnt;
  logic              r_win_valid, r_err;
  logic [WIN_W-1:0]  r_filt, w_win;
  logic [PIX_W-1:0]  r_img [IMG_N];

  logic              w_start, w_last_word, w_hs, w_res_ok, w_res_bad;
  logic [31:0]       w_hs_total;
  logic              w_filt_we [PPW];
  int                w_filt_idx [PPW];
  logic              w_img_we [PPW];
  logic [PIX_AW-1:0] w_img_addr [PPW];

  assign w_start     = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last_word = (r_state == S_LOAD_FILT) ? (r_word_cnt == 32'(FW - 1))
                                                : (r_word_cnt == 32'(IW - 1));
  assign w_hs        = r_win_valid && win_ready;
  // A write may target the window handshaken in the very same cycle.
  assign w_hs_total  = r_hs_cnt + {31'd0, w_hs};
  assign w_res_ok    = (r_state == S_CONV) && res_valid && (r_wr_cnt < w_hs_total);
  assign w_res_bad   = (r_state == S_CONV) && res_valid && !(r_wr_cnt < w_hs_total);

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_LOAD_FILT;
      S_LOAD_FILT: begin
        busy     = 1'b1;
        in_ready = filt_valid;
        if (filt_valid && w_last_word) w_next = S_LOAD_IMG;
      end
      S_LOAD_IMG: begin
        busy     = 1'b1;
        in_ready = img_valid;
        if (img_valid && w_last_word) w_next = S_CONV;
      end
      S_CONV: begin
        busy = 1'b1;
        if (r_wr_cnt == 32'(N_WIN)) w_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_next = S_LOAD_FILT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Per-lane targets of the current load word; surplus lanes are masked off.
  always_comb begin
    for (int p = 0; p < PPW; p++) begin
      w_filt_idx[p] = int'(r_pix_cnt) + p;
      w_filt_we[p]  = (int'(r_pix_cnt) + p) < K * K;
      w_img_addr[p] = PIX_AW'(int'(r_pix_cnt) + p);
      w_img_we[p]   = (int'(r_pix_cnt) + p) < IMG_N;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_word_cnt  <= '0;
      r_pix_cnt   <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_hs_cnt    <= '0;
      r_wr_cnt    <= '0;
      r_win_valid <= 1'b0;
      r_err       <= 1'b0;
      r_filt      <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_word_cnt  <= '0;
        r_pix_cnt   <= '0;
        r_col       <= '0;
        r_row       <= '0;
        r_hs_cnt    <= '0;
        r_wr_cnt    <= '0;
        r_win_valid <= 1'b0;
        r_err       <= 1'b0;
      end else begin
        if (in_ready) begin
          if (w_last_word) begin
            r_word_cnt <= '0;
            r_pix_cnt  <= '0;
          end else begin
            r_word_cnt <= r_word_cnt + 32'd1;
            r_pix_cnt  <= r_pix_cnt + 32'(PPW);
          end
        end
        if (r_state == S_LOAD_FILT && filt_valid) begin
          for (int p = 0; p < PPW; p++) begin
            if (w_filt_we[p]) r_filt[w_filt_idx[p]*PIX_W +: PIX_W] <= in_data[p*PIX_W +: PIX_W];
          end
        end
        if (r_state == S_LOAD_IMG && img_valid && w_last_word) r_win_valid <= 1'b1;
        if (w_hs) begin
          r_hs_cnt <= r_hs_cnt + 32'd1;
          if (r_col == 32'(OW - 1)) begin
            r_col <= '0;
            r_row <= r_row + 32'd1;
          end else begin
            r_col <= r_col + 32'd1;
          end
          if (r_hs_cnt == 32'(N_WIN - 1)) r_win_valid <= 1'b0;
        end
        if (w_res_ok)  r_wr_cnt <= r_wr_cnt + 32'd1;
        if (w_res_bad) r_err    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_LOAD_IMG && img_valid) begin
      for (int p = 0; p < PPW; p++) begin
        if (w_img_we[p]) r_img[w_img_addr[p]] <= in_data[p*PIX_W +: PIX_W];
      end
    end
  end

  // Taps outside the image read as zero (only reachable with padding).
  always_comb begin
    int pr, pc;
    pr    = 0;
    pc    = 0;
    w_win = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        pr = int'(r_row) + i - PAD;
        pc = int'(r_col) + j - PAD;
        if (pr >= 0 && pr < IMG_H && pc >= 0 && pc < IMG_W)
          w_win[win_idx(i, j, K)*PIX_W +: PIX_W] = r_img[PIX_AW'(pr * IMG_W + pc)];
      end
    end
  end

  assign win_valid = r_win_valid;
  assign win_data  = w_win;
  assign filt_data = r_filt;
  assign err       = r_err;

  cwb_res_mem #(
    .DEPTH (N_WIN),
    .RES_W (RES_W),
    .AW    (RA_W)
  ) u_res_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_res_ok),
    .wr_addr (r_wr_cnt[RA_W-1:0]),
    .wr_data (res_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_conv_window_buf.sv
//------------------------------------------------------------------------------
// Module  : tb_conv_window_buf
// Brief   : Directed bench for conv_window_buf at default parameters;
//           expectations follow CWB_ZERO_PAD_EN when it is defined.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_conv_window_buf;

`ifdef CWB_ZERO_PAD_EN
  localparam int PAD = 1;
  localparam logic [71:0] W0 = 72'h1F1E00010000000000;
`else
  localparam int PAD = 0;
  localparam logic [71:0] W0  = 72'h3E3D3C201F1E020100;
  localparam logic [71:0] W28 = 72'h5C5B5A3E3D3C201F1E;
`endif
  localparam int OW    = 30 - 3 + 1 + 2 * PAD;
  localparam int OH    = 30 - 3 + 1 + 2 * PAD;
  localparam int N_WIN = OW * OH;
  localparam int RA_W  = $clog2(N_WIN);
  localparam int IW    = 225;
  localparam logic [71:0] FILT = 72'h090807060504030201;

  logic              clk = 1'b0;
  logic              rst, start, filt_valid, img_valid, in_ready;
  logic [31:0]       in_data;
  logic              win_valid, win_ready, res_valid, busy, done, err;
  logic [71:0]       win_data, filt_data;
  logic [19:0]       res_data, rd_data;
  logic [RA_W-1:0]   rd_addr;
  logic [31:0]       fw [3];

  int n_pass = 0;
  int n_chk  = 0;
  int hs, t;

  conv_window_buf dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .filt_valid (filt_valid),
    .img_valid  (img_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_data   (win_data),
    .filt_data  (filt_data),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] img_word(input int w);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[8*k +: 8] = 8'((4 * w + k) % 256);
    return v;
  endfunction

  // Reference window: pixel(r,c) = (r*30+c) mod 256, zero outside the image.
  function automatic logic [71:0] exp_win(input int wi);
    logic [71:0] v;
    int pr, pc;
    v = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        pr = wi / OW + i - PAD;
        pc = wi % OW + j - PAD;
        if (pr >= 0 && pr < 30 && pc >= 0 && pc < 30) v[(i*3+j)*8 +: 8] = 8'((pr * 30 + pc) % 256);
      end
    end
    return v;
  endfunction

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic load_filter();
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      filt_valid = 1'b1;
      img_valid  = (w == 0);
      in_data    = fw[w];
      #1 chk("filt_in_ready", in_ready, 1);
    end
    @(negedge clk);
    filt_valid = 1'b0;
    img_valid  = 1'b0;
  endtask

  task automatic load_image(input int nwords);
    for (int w = 0; w < nwords; w++) begin
      @(negedge clk);
      img_valid  = 1'b1;
      filt_valid = (w == 0);
      in_data    = img_word(w);
      #1 chk("img_in_ready", in_ready, 1);
    end
    @(negedge clk);
    img_valid  = 1'b0;
    filt_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fw[0] = 32'h04030201;
    fw[1] = 32'h08070605;
    fw[2] = 32'h00000009;
    rst = 1'b1; start = 1'b0; filt_valid = 1'b1; img_valid = 1'b1; in_data = '0;
    win_ready = 1'b0; res_valid = 1'b0; res_data = '0; rd_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_filt_data", filt_data, 0);
    chk("rst_rd_data", rd_data, 0);
    filt_valid = 1'b0; img_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Frame aborted by reset part-way through the image.
    do_start();
    chk("busy_after_start", busy, 1);
    load_filter();
    load_image(100);
    @(negedge clk);
    rst = 1'b1; img_valid = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_filt_data", filt_data, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_ignores_img", in_ready, 0);
    chk("idle_busy", busy, 0);
    img_valid = 1'b0;

    // Full frame.
    do_start();
    chk("restart_busy", busy, 1);
    chk("restart_done", done, 0);
    @(negedge clk);
    img_valid = 1'b1;
    #1 chk("filt_state_rejects_img", in_ready, 0);
    img_valid = 1'b0;
    load_filter();
    chk("filt_data", filt_data, FILT);
    @(negedge clk);
    filt_valid = 1'b1; res_valid = 1'b1;
    #1 chk("img_state_rejects_filt", in_ready, 0);
    @(negedge clk);
    filt_valid = 1'b0; res_valid = 1'b0;
    #1 chk("res_outside_conv_ignored", err, 0);
    load_image(IW);

    t = 0;
    while (!win_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    #1;
    chk("win_valid_rise", win_valid, 1);
    chk("win0_const", win_data, W0);

    // Stall with win_ready low; an early result must flag err.
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      win_ready = 1'b0;
      res_valid = (s == 0);
      #1;
      chk("stall_win_data", win_data, W0);
      chk("stall_win_valid", win_valid, 1);
    end
    res_valid = 1'b0;
    chk("early_res_err", err, 1);

    // Stream windows; each handshake carries the result for the previous window.
    hs = 0;
    t  = 0;
    while (hs < N_WIN && t < 3000) begin
      @(negedge clk);
      t++;
      if (win_valid) begin
        chk("win_data", win_data, exp_win(hs));
`ifndef CWB_ZERO_PAD_EN
        if (hs == 28) chk("win28_const", win_data, W28);
`endif
        win_ready = 1'b1;
        res_valid = (hs > 0);
        res_data  = 20'(hs - 1);
        hs++;
      end else begin
        win_ready = 1'b0;
        res_valid = 1'b0;
      end
    end
    chk("handshake_count", hs, N_WIN);
    @(negedge clk);
    win_ready = 1'b0;
    res_valid = 1'b0;
    #1;
    chk("win_valid_after_last", win_valid, 0);
    chk("done_before_last_res", done, 0);
    res_valid = 1'b1;
    res_data  = 20'(N_WIN - 1);
    @(negedge clk);
    res_valid = 1'b0;
    t = 0;
    while (!done && t < 10) begin
      @(negedge clk);
      t++;
    end
    #1;
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("err_sticky", err, 1);

    @(negedge clk);
    rd_addr = RA_W'(N_WIN - 1);
    @(negedge clk);
    #1 chk("rd_last", rd_data, N_WIN - 1);
    rd_addr = RA_W'(28);
    @(negedge clk);
    #1 chk("rd_28", rd_data, 28);
    rd_addr = RA_W'(1);
    @(negedge clk);
    #1 chk("rd_1", rd_data, 1);
    rd_addr = RA_W'(N_WIN + 16);
    @(negedge clk);
    #1 chk("rd_out_of_range", rd_data, 0);

    do_start();
    chk("start_clears_err", err, 0);
    chk("start_busy", busy, 1);
    chk("start_clears_done", done, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/conv_window_buf.md
CONV_WINDOW_BUF -- requirements
Module: conv_window_buf

Interface
REQ-001 SHALL have parameter IMG_W, default 30, image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 30, image height in pixels.
REQ-003 SHALL have parameter K, default 3, square kernel size; K <= IMG_W and K <= IMG_H.
REQ-004 SHALL have parameter PIX_W, default 8, pixel/coefficient width.
REQ-005 SHALL have parameter IN_W, default 32, load word width; IN_W is a multiple of PIX_W.
REQ-006 SHALL have parameter RES_W, default 20, result width.
REQ-007 SHALL have port clk, input, 1: single clock, rising edge.
REQ-008 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-009 SHALL have port start, input, 1: begin a new frame.
REQ-010 SHALL have ports filt_valid and img_valid, input, 1 each: the load word is a filter word or an image word.
REQ-011 SHALL have port in_data, input, IN_W: packed pixels, LSB pixel first.
REQ-012 SHALL have port in_ready, output, 1: load word accepted this cycle.
REQ-013 SHALL have ports win_valid (output, 1), win_ready (input, 1) and win_data (output, K*K*PIX_W): KxK window, row-major, LSB first.
REQ-014 SHALL have port filt_data, output, K*K*PIX_W: stored filter, same packing as win_data.
REQ-015 SHALL have ports res_valid (input, 1) and res_data (input, RES_W): result write-back.
REQ-016 SHALL have ports rd_addr (input, clog2(OW*OH)) and rd_data (output, RES_W), where OW = IMG_W-K+1 and OH = IMG_H-K+1.
REQ-017 SHALL have ports busy, done and err, outputs, 1 each.

Function
REQ-018 SHALL implement FSM IDLE -> LOAD_FILT -> LOAD_IMG -> CONV -> DONE; start in IDLE or DONE enters LOAD_FILT and clears all counters and err; start is ignored in any other state.
REQ-019 In LOAD_FILT, in_ready SHALL equal filt_valid; FW = ceil(K*K*PIX_W/IN_W) words are accepted; surplus pixels in the last word are discarded; the FSM then goes to LOAD_IMG.
REQ-020 In LOAD_IMG, in_ready SHALL equal img_valid; IW = ceil(IMG_W*IMG_H*PIX_W/IN_W) words are accepted with pixels packed continuously across row boundaries; the FSM then goes to CONV.
REQ-021 A valid that does not match the current state (e.g. img_valid in LOAD_FILT) SHALL be ignored, with in_ready low; when both valids are high, only the one matching the state SHALL be taken.
REQ-022 win_valid SHALL rise on the first cycle after CONV entry; windows are issued in raster order, column index fastest, OW*OH in total.
REQ-023 win_data SHALL hold stable while win_valid && !win_ready; the window advances one position per handshake and wraps to column 0 of the next row after column OW-1.
REQ-024 Each res_valid SHALL write res_data to result address wr_cnt (raster order) and increment wr_cnt; res_valid in the same cycle as a window handshake is legal.
REQ-025 When res_valid arrives with wr_cnt >= the number of completed window handshakes, err SHALL be set (sticky until start or rst) and the write dropped; res_valid outside CONV SHALL be ignored.
REQ-026 The FSM SHALL go CONV -> DONE when wr_cnt reaches OW*OH; done is high in DONE; busy is high in LOAD_FILT, LOAD_IMG and CONV.
REQ-027 rd_data SHALL be the registered result at rd_addr with 1-cycle latency; an address >= OW*OH SHALL return 0.

Reset
REQ-028 rst SHALL force state IDLE, all counters 0, in_ready=0, win_valid=0, busy=0, done=0, err=0, filt_data=0 and rd_data=0; image and result storage need not be cleared.
REQ-029 rst asserted mid-frame SHALL abort the frame; after release, only start resumes operation.

Configuration
REQ-030 With CWB_ZERO_PAD_EN defined, the image SHALL be zero-padded by (K-1)/2 on every side, so that OW = IMG_W, OH = IMG_H and rd_addr is sized to match; without it, the valid-only geometry of REQ-016 applies.

Structure
REQ-031 The state enum, the OW/OH/FW/IW derivation functions and the window-packing index function SHALL reside in package cwb_pkg.
REQ-032 Result storage with its read port SHALL be a sub-module cwb_res_mem; the FSM, counters and window extraction SHALL remain in conv_window_buf.

Verification
REQ-033 Defaults: filter words 0x04030201, 0x08070605, 0x00000009, then image pixel(r,c) = r*30+c mod 256 -> first win_data = pixels {0,1,2,30,31,32,60,61,62}, filt_data = 1..9.
REQ-034 win_ready held low for 5 cycles -> win_data is unchanged; 784 handshakes are completed; window 28 (0-based) starts at pixel (1,0).
REQ-035 784 res_valid with res_data = index -> done=1 and rd_addr=783 gives rd_data=783 one cycle later; rd_addr=800 gives 0.
REQ-036 res_valid before any window handshake -> err=1, wr_cnt stays 0; a subsequent start clears err.
REQ-037 rst pulsed after 100 image words, then start -> busy=1 and state LOAD_FILT; a full new frame completes correctly.
REQ-038 With CWB_ZERO_PAD_EN defined -> first win_data = {0,0,0,0,0,1,0,30,31}, 900 windows are issued.
